maf_issue_ctrl: RTL and testbench

MAF_ISSUE_CTRL -- requirements
Module: maf_issue_ctrl

---
 rtl/maf_pkg.sv | 30 +++
 rtl/maf_pipe_track.sv | 58 +++++
 rtl/maf_issue_ctrl.sv | 153 +++++++++++++++
 tb/tb_maf_issue_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maf_pkg.sv
// Shared encodings for the MAF issue controller: request modes, datapath
// container codes and pairing FSM states.
package maf_pkg;

  typedef enum logic [1:0] {
    MODE_DOUBLE = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_ILL_A  = 2'b10,
    MODE_ILL_B  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    CONT_DOUBLE = 3'b000,
    CONT_DUAL   = 3'b001,
    CONT_LONE   = 3'b010
  } cont_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Wide enough for any TIMEOUT up to 15.
  localparam int CNT_W = 4;

  function automatic logic mode_illegal(input logic [1:0] mode);
    return mode[1];
  endfunction

endpackage

// File: rtl/maf_pipe_track.sv
// Stage register chain mirroring the MAF datapath: carries valid, container
// mode and lane tags from issue to the last stage, advancing only on adv.
module maf_pipe_track
  import maf_pkg::*;
#(
  parameter int LAT   = 3,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [2:0]       in_cont,
  input  logic [TAG_W-1:0] in_tag_l,
  input  logic [TAG_W-1:0] in_tag_h,
  output logic             out_valid,
  output logic [2:0]       out_cont,
  output logic [TAG_W-1:0] out_tag_l,
  output logic [TAG_W-1:0] out_tag_h
);

  logic [LAT-1:0]   valid;
  logic [2:0]       cont  [LAT];
  logic [TAG_W-1:0] tag_l [LAT];
  logic [TAG_W-1:0] tag_h [LAT];

  // Flush only kills valids; stale payload behind a cleared valid is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < LAT; i++) begin
        cont[i]  <= '0;
        tag_l[i] <= '0;
        tag_h[i] <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else if (adv) begin
      valid[0] <= in_valid;
      cont[0]  <= in_cont;
      tag_l[0] <= in_tag_l;
      tag_h[0] <= in_tag_h;
      for (int i = 1; i < LAT; i++) begin
        valid[i] <= valid[i-1];
        cont[i]  <= cont[i-1];
        tag_l[i] <= tag_l[i-1];
        tag_h[i] <= tag_h[i-1];
      end
    end
  end

  assign out_valid = valid[LAT-1];
  assign out_cont  = cont[LAT-1];
  assign out_tag_l = tag_l[LAT-1];
  assign out_tag_h = tag_h[LAT-1];

endmodule

// File: rtl/maf_issue_ctrl.sv
// Issue controller for a multiply-add-fused unit: pairs single-precision
// requests into packed dual-single operations and tracks results to retirement.
module maf_issue_ctrl
  import maf_pkg::*;
#(
  parameter int LAT     = 3,
  parameter int TIMEOUT = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             dp_en,
  output logic             dp_valid,
  output logic [2:0]       dp_cont,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_cont,
  output logic [TAG_W-1:0] rsp_tag_l,
  output logic [TAG_W-1:0] rsp_tag_h,
  output logic             err_illegal,
  output logic             dbg_state
);

  // Handshake: a request transfers on a cycle where req_valid & req_ready are
  // both high; a result retires on a cycle where rsp_valid & rsp_ready are.

  state_e           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [TAG_W-1:0] held_tag, held_tag_nx;

  logic             last_valid;
  logic             adv;
  logic             hold_dbl;
  logic             accept;
  logic             issue;
  cont_e            issue_cont;
  logic [TAG_W-1:0] issue_tag_l;
  logic [TAG_W-1:0] issue_tag_h;

  always_comb begin
    adv         = ~last_valid | rsp_ready;
    // A double arriving behind a held single must wait one advance so the
    // single leaves first and program order is kept.
    hold_dbl    = (state == ST_HOLD) & req_valid & (req_mode == MODE_DOUBLE);
    req_ready   = rst_n & ~flush & adv & ~hold_dbl;
    accept      = req_valid & req_ready;
    err_illegal = accept & mode_illegal(req_mode);

    issue       = 1'b0;
    issue_cont  = CONT_DOUBLE;
    issue_tag_l = '0;
    issue_tag_h = '0;
    state_nx    = state;
    cnt_nx      = cnt;
    held_tag_nx = held_tag;

    if (rst_n && !flush && adv) begin
      unique case (state)
        ST_IDLE: begin
          if (accept && req_mode == MODE_DOUBLE) begin
            issue       = 1'b1;
            issue_cont  = CONT_DOUBLE;
            issue_tag_l = req_tag;
          end else if (accept && req_mode == MODE_SINGLE) begin
            state_nx    = ST_HOLD;
            cnt_nx      = '0;
            held_tag_nx = req_tag;
          end
        end
        ST_HOLD: begin
          if (accept && req_mode == MODE_SINGLE) begin
            issue       = 1'b1;
            issue_cont  = CONT_DUAL;
            issue_tag_l = held_tag;
            issue_tag_h = req_tag;
            state_nx    = ST_IDLE;
            cnt_nx      = '0;
          end else if (hold_dbl) begin
            issue       = 1'b1;
            issue_cont  = CONT_LONE;
            issue_tag_l = held_tag;
            state_nx    = ST_IDLE;
            cnt_nx      = '0;
          end else if (!req_valid) begin
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              issue       = 1'b1;
              issue_cont  = CONT_LONE;
              issue_tag_l = held_tag;
              state_nx    = ST_IDLE;
              cnt_nx      = '0;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      held_tag <= '0;
    end else if (flush) begin
      state    <= ST_IDLE;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      held_tag <= held_tag_nx;
    end
  end

  assign dp_en     = adv;
  assign dp_valid  = issue;
  assign dp_cont   = issue_cont;
  assign dbg_state = state;

  maf_pipe_track #(
    .LAT   (LAT),
    .TAG_W (TAG_W)
  ) u_track (
    .clk       (clk),
    .rst_n     (rst_n),
    .adv       (adv),
    .flush     (flush),
    .in_valid  (issue),
    .in_cont   (issue_cont),
    .in_tag_l  (issue_tag_l),
    .in_tag_h  (issue_tag_h),
    .out_valid (last_valid),
    .out_cont  (rsp_cont),
    .out_tag_l (rsp_tag_l),
    .out_tag_h (rsp_tag_h)
  );

  assign rsp_valid = last_valid;

  a_issue_needs_adv : assert property (@(posedge clk) disable iff (!rst_n)
    dp_valid |-> dp_en);
  a_no_accept_on_flush : assert property (@(posedge clk) disable iff (!rst_n)
    flush |-> !req_ready);
  a_dual_only_from_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (dp_valid && dp_cont == CONT_DUAL) |-> state == ST_HOLD);

endmodule

// File: tb/tb_maf_issue_ctrl.sv
// Bench for maf_issue_ctrl: directed vector table, hand-written stall/flush/
// reset sequences and random traffic checked against a queue-based model.
module tb_maf_issue_ctrl;

  localparam int LAT     = 3;
  localparam int TIMEOUT = 4;
  localparam int TAG_W   = 4;
  localparam int IW      = 3 + 2 * TAG_W;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_mode;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             dp_en;
  logic             dp_valid;
  logic [2:0]       dp_cont;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2:0]       rsp_cont;
  logic [TAG_W-1:0] rsp_tag_l;
  logic [TAG_W-1:0] rsp_tag_h;
  logic             err_illegal;
  logic             dbg_state;

  int checks = 0;
  int errors = 0;

  maf_issue_ctrl #(.LAT(LAT), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_mode    (req_mode),
    .req_tag     (req_tag),
    .flush       (flush),
    .dp_en       (dp_en),
    .dp_valid    (dp_valid),
    .dp_cont     (dp_cont),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_cont    (rsp_cont),
    .rsp_tag_l   (rsp_tag_l),
    .rsp_tag_h   (rsp_tag_h),
    .err_illegal (err_illegal),
    .dbg_state   (dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: held single (if any) plus an in-flight queue of
  // {cont, tag_l, tag_h} with the number of advances each has seen.
  bit               m_held;
  logic [TAG_W-1:0] m_tag;
  int               m_wait;
  logic [IW-1:0]    exp_q[$];
  int               age_q[$];

  logic             e_rsp_v, e_adv, e_ready, e_iss, e_err;
  logic [IW-1:0]    e_item, e_front;
  bit               n_held;
  logic [TAG_W-1:0] n_tag;
  int               n_wait;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    age_q.delete();
    m_held = 0;
    m_tag  = '0;
    m_wait = 0;
  endtask

  task automatic model_eval();
    logic blk, acc;
    e_rsp_v = (exp_q.size() > 0) && (age_q[0] == LAT);
    e_front = (exp_q.size() > 0) ? exp_q[0] : '0;
    e_adv   = !e_rsp_v || rsp_ready;
    blk     = m_held && req_valid && (req_mode == 2'b00);
    e_ready = e_adv && !flush && !blk;
    acc     = req_valid && e_ready;
    e_err   = acc && req_mode[1];
    e_iss   = 1'b0;
    e_item  = '0;
    n_held  = m_held;
    n_tag   = m_tag;
    n_wait  = m_wait;
    if (!flush && e_adv) begin
      if (!m_held) begin
        if (acc && req_mode == 2'b00) begin
          e_iss  = 1'b1;
          e_item = {3'b000, req_tag, {TAG_W{1'b0}}};
        end else if (acc && req_mode == 2'b01) begin
          n_held = 1;
          n_tag  = req_tag;
          n_wait = 0;
        end
      end else if (acc && req_mode == 2'b01) begin
        e_iss  = 1'b1;
        e_item = {3'b001, m_tag, req_tag};
        n_held = 0;
      end else if (blk || (!req_valid && m_wait == TIMEOUT - 1)) begin
        e_iss  = 1'b1;
        e_item = {3'b010, m_tag, {TAG_W{1'b0}}};
        n_held = 0;
      end else if (!req_valid) begin
        n_wait = m_wait + 1;
      end
    end
  endtask

  task automatic model_commit();
    if (flush) begin
      exp_q.delete();
      age_q.delete();
      m_held = 0;
      m_wait = 0;
    end else if (e_adv) begin
      if (e_rsp_v) begin
        void'(exp_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (e_iss) begin
        exp_q.push_back(e_item);
        age_q.push_back(1);
      end
      m_held = n_held;
      m_tag  = n_tag;
      m_wait = n_wait;
    end
  endtask

  // Driver tasks
  task automatic drive(input logic v, input logic [1:0] m, input logic [TAG_W-1:0] t,
                       input logic rr, input logic fl);
    req_valid = v;
    req_mode  = m;
    req_tag   = t;
    rsp_ready = rr;
    flush     = fl;
  endtask

  task automatic sample_and_check();
    #3;
    model_eval();
    chk("dp_en", 32'(dp_en), 32'(e_adv));
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("dp_valid", 32'(dp_valid), 32'(e_iss));
    if (e_iss) chk("dp_cont", 32'(dp_cont), 32'(e_item[IW-1 -: 3]));
    chk("err_illegal", 32'(err_illegal), 32'(e_err));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp_v));
    if (e_rsp_v) begin
      chk("rsp_cont", 32'(rsp_cont), 32'(e_front[IW-1 -: 3]));
      chk("rsp_tag_l", 32'(rsp_tag_l), 32'(e_front[2*TAG_W-1 -: TAG_W]));
      if (e_front[IW-1 -: 3] == 3'b001)
        chk("rsp_tag_h", 32'(rsp_tag_h), 32'(e_front[TAG_W-1:0]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic cycle(input logic v, input logic [1:0] m, input logic [TAG_W-1:0] t,
                       input logic rr, input logic fl);
    drive(v, m, t, rr, fl);
    sample_and_check();
    tick();
  endtask

  task automatic reset_outputs_check(input string name);
    chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({name, "_dp_valid"}, 32'(dp_valid), 32'd0);
    chk({name, "_err"}, 32'(err_illegal), 32'd0);
    chk({name, "_rsp_cont"}, 32'(rsp_cont), 32'd0);
    chk({name, "_rsp_tag_l"}, 32'(rsp_tag_l), 32'd0);
    chk({name, "_rsp_tag_h"}, 32'(rsp_tag_h), 32'd0);
  endtask

  typedef struct {
    logic             v;
    logic [1:0]       m;
    logic [TAG_W-1:0] tag;
    logic             e_ready;
    logic             e_dpv;
    logic [2:0]       e_cont;
    logic             e_err;
    logic             e_rspv;
    logic [2:0]       e_rcont;
    logic [TAG_W-1:0] e_tl;
    logic [TAG_W-1:0] e_th;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl[NV];

  task automatic set_vec(input int i, input logic v, input logic [1:0] m, input logic [TAG_W-1:0] t,
                         input logic rdy, input logic dpv, input logic [2:0] c, input logic err,
                         input logic rv, input logic [2:0] rc, input logic [TAG_W-1:0] tl,
                         input logic [TAG_W-1:0] th);
    tbl[i] = '{v, m, t, rdy, dpv, c, err, rv, rc, tl, th};
  endtask

  int seen;

  initial begin
    // Directed table (rsp_ready held high, no flush); idle rows by default.
    for (int i = 0; i < NV; i++) set_vec(i, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    set_vec(0,  1, 2'b00, 3, 1, 1, 3'b000, 0, 0, 0, 0, 0);
    set_vec(3,  0, 2'b00, 0, 1, 0, 3'b000, 0, 1, 3'b000, 3, 0);
    set_vec(4,  1, 2'b01, 1, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    set_vec(5,  1, 2'b01, 2, 1, 1, 3'b001, 0, 0, 0, 0, 0);
    set_vec(8,  0, 2'b00, 0, 1, 0, 3'b000, 0, 1, 3'b001, 1, 2);
    set_vec(9,  1, 2'b01, 6, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    set_vec(10, 1, 2'b00, 7, 0, 1, 3'b010, 0, 0, 0, 0, 0);
    set_vec(11, 1, 2'b00, 7, 1, 1, 3'b000, 0, 0, 0, 0, 0);
    set_vec(13, 0, 2'b00, 0, 1, 0, 3'b000, 0, 1, 3'b010, 6, 0);
    set_vec(14, 0, 2'b00, 0, 1, 0, 3'b000, 0, 1, 3'b000, 7, 0);
    set_vec(16, 1, 2'b01, 5, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    set_vec(20, 0, 2'b00, 0, 1, 1, 3'b010, 0, 0, 0, 0, 0);
    set_vec(23, 0, 2'b00, 0, 1, 0, 3'b000, 0, 1, 3'b010, 5, 0);
    set_vec(24, 1, 2'b10, 9, 1, 0, 3'b000, 1, 0, 0, 0, 0);

    // Reset with a request present: nothing may issue.
    rst_n = 1'b0;
    drive(1, 2'b00, 4'hA, 1, 0);
    #3;
    reset_outputs_check("por");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].tag, 1'b1, 1'b0);
      sample_and_check();
      chk($sformatf("t%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_ready));
      chk($sformatf("t%0d_dp_valid", i), 32'(dp_valid), 32'(tbl[i].e_dpv));
      if (tbl[i].e_dpv) chk($sformatf("t%0d_dp_cont", i), 32'(dp_cont), 32'(tbl[i].e_cont));
      chk($sformatf("t%0d_err", i), 32'(err_illegal), 32'(tbl[i].e_err));
      chk($sformatf("t%0d_rsp_valid", i), 32'(rsp_valid), 32'(tbl[i].e_rspv));
      if (tbl[i].e_rspv) begin
        chk($sformatf("t%0d_rsp_cont", i), 32'(rsp_cont), 32'(tbl[i].e_rcont));
        chk($sformatf("t%0d_rsp_tag_l", i), 32'(rsp_tag_l), 32'(tbl[i].e_tl));
        if (tbl[i].e_rcont == 3'b001)
          chk($sformatf("t%0d_rsp_tag_h", i), 32'(rsp_tag_h), 32'(tbl[i].e_th));
      end
      tick();
    end

    // Back-pressure with LAT results in flight, then drain in order.
    cycle(1, 2'b00, 1, 1, 0);
    cycle(1, 2'b00, 2, 1, 0);
    cycle(1, 2'b00, 3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b00, 4, 0, 0);
      sample_and_check();
      chk("stall_dp_en", 32'(dp_en), 32'd0);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
      chk("stall_tag_stable", 32'(rsp_tag_l), 32'd1);
      tick();
    end
    for (int i = 1; i <= 3; i++) begin
      drive(0, 2'b00, 0, 1, 0);
      sample_and_check();
      chk("drain_order", 32'(rsp_tag_l), 32'(i));
      tick();
    end
    cycle(0, 2'b00, 0, 1, 0);

    // Flush while holding a single with the pipeline stalled.
    cycle(1, 2'b00, 8, 1, 0);
    cycle(1, 2'b00, 9, 1, 0);
    cycle(1, 2'b01, 11, 1, 0);
    cycle(0, 2'b00, 0, 0, 0);
    drive(1, 2'b01, 12, 0, 1);
    sample_and_check();
    chk("flush_req_ready", 32'(req_ready), 32'd0);
    tick();
    seen = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      drive(0, 2'b00, 0, 1, 0);
      sample_and_check();
      if (rsp_valid) seen++;
      tick();
    end
    chk("flush_rsp_seen", 32'(seen), 32'd0);
    // Held single 11 must be gone: a new single times out alone.
    cycle(1, 2'b01, 13, 1, 0);
    for (int i = 0; i < TIMEOUT + LAT + 1; i++) cycle(0, 2'b00, 0, 1, 0);

    // Asynchronous reset mid-operation.
    cycle(1, 2'b00, 14, 1, 0);
    cycle(1, 2'b01, 15, 1, 0);
    drive(1, 2'b00, 4'hB, 1, 0);
    rst_n = 1'b0;
    #3;
    reset_outputs_check("mid");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < LAT + TIMEOUT + 1; i++) begin
      drive(0, 2'b00, 0, 1, 0);
      sample_and_check();
      if (rsp_valid) seen++;
      tick();
    end
    chk("reset_rsp_seen", 32'(seen), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic v, rr, fl;
      logic [1:0] m;
      int r;
      v  = ($urandom_range(0, 99) < 60);
      r  = $urandom_range(0, 99);
      m  = (r < 45) ? 2'b00 : (r < 92) ? 2'b01 : 2'($urandom_range(2, 3));
      rr = ($urandom_range(0, 99) < 75);
      fl = ($urandom_range(0, 99) < 3);
      cycle(v, m, TAG_W'($urandom_range(0, 15)), rr, fl);
    end
    for (int i = 0; i < LAT + TIMEOUT + 2; i++) cycle(0, 2'b00, 0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
